mem_stall_responder: RTL and testbench
======================================

# mem_stall_responder

Memory-side responder for the processor's data-memory port: accepts one read or write request at a time from the initiator, holds it for a parameterised number of cycles while signalling stall, then completes with a one-cycle done pulse and read data. It replaces the zero-latency `memory2c` data path so the pipeline's stall handling can be exercised. Storage is an internal word array of 16-bit words, addressed by byte address.

## Interface
- `ADDR_BITS`, default 8: word-index width; array holds 2^ADDR_BITS 16-bit words.
- `LATENCY`, default 3: cycles from request acceptance to done. Legal range 1..15.

- `clk`  input  1  system clock, all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `rd`  input  1  read request.
- `wr`  input  1  write request.
- `addr`  input  16  byte address. Bit 0 must be 0.
- `data_in`  input  16  write data, sampled with the request.
- `data_out`  output  16  read data, valid while `done`=1.
- `stall`  output  1  request in flight, not yet complete.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  request rejected, qualified by `done`.

## Operation
- States: IDLE, BUSY, DONE.
- Accept condition: state IDLE or DONE, and (`rd` | `wr`). When accepted, `addr`, `data_in` and the request type are latched. A request presented in BUSY is ignored and is not queued. The initiator holds or re-presents the request.
- Error check at acceptance: any of the following conditions produces an error completion.
  - `rd` & `wr` both high.
  - `addr[0]`=1 (misaligned).
  - `addr[15:ADDR_BITS+1]` nonzero (out of range).
- Error completion behaviour:
  - It bypasses BUSY and goes to DONE next cycle with `err`=1.
  - It makes no array access, and `data_out` is 0.
  - LATENCY has no effect on error completions.
- Valid request:
  - If LATENCY=1, the block goes straight to DONE. Otherwise it goes to BUSY with a 4-bit counter loaded to LATENCY-2, decrements each BUSY cycle, and moves to DONE when the counter is 0.
- Array access:
  - Word index is `addr[ADDR_BITS:1]`.
  - A write commits to the array on the edge entering DONE.
  - A read captures the array word into the `data_out` register on the same edge.
- DONE lasts exactly one cycle. From DONE the block goes to IDLE, or it accepts a new request (back-to-back).
- `data_out` holds its last value after DONE, but it is only defined while `done`=1. After a write completion, `data_out` is 0.
- Reset clears state to IDLE and forces `stall`=0, `done`=0, `err`=0, `data_out`=0. It clears the latched request and counter.
- Array contents are not reset. A write in flight when reset asserts is discarded.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- Request sampled high at the end of cycle n (accepted):
  - `stall`=1 in cycles n+1 .. n+LATENCY-1 (none when LATENCY=1).
  - `done`=1 in cycle n+LATENCY only.
  - `data_out` is valid in cycle n+LATENCY.
- Error: `done`=`err`=1 in cycle n+1, `stall` stays 0.
- `stall` and `done` are never high together.
- A back-to-back request presented in the DONE cycle (n+LATENCY) is accepted. Its `stall` rises in the next cycle, so there is no idle gap.
- Read-after-write to the same address with back-to-back requests returns the new data.
- Reset asserted asynchronously mid-BUSY drops `stall` immediately, with no `done` following. After reset deasserts, the first request behaves as from IDLE.

## Test plan
- Reset: assert `rst` mid-cycle with arbitrary inputs. Required: `stall`/`done`/`err`=0 and `data_out`=0 immediately. Release `rst`, issue no request: outputs stay 0 for 10 cycles.
- LATENCY=3, write then read:
  - Write `addr`=0x0010, `data_in`=0xBEEF in cycle 0: `stall`=1 in cycles 1-2, `done`=1 in cycle 3, `err`=0.
  - Read 0x0010 presented in cycle 3 (back-to-back): `done` in cycle 6, `data_out`=0xBEEF.
- Errors, LATENCY=3:
  - Read of `addr`=0x0011: `done`=`err`=1 in cycle 1, `data_out`=0, `stall` never high.
  - Repeat with `rd`=`wr`=1 at 0x0020: same response.
  - A following read of 0x0020 returns its prior contents (unchanged).
  - `addr`=0x0200 with ADDR_BITS=8: error.
- Request while BUSY, LATENCY=4:
  - Write 0x0004=0x1234 in cycle 0, then hold write 0x0006=0x5678 in cycles 1-3, released in cycle 4. The second write is not accepted in cycles 1-3.
  - Exactly one `done`, in cycle 4.
  - A later read of 0x0006 returns old data.
- Reset mid-operation: write 0x0008=0xAAAA (old value 0x5555), assert `rst` in cycle 2 of 3. Required: no `done`; a subsequent read of 0x0008 returns 0x5555.
- LATENCY=1:
  - Alternating write/read every cycle to 0x0000..0x000E: `stall` never high and `done` high every cycle.
  - Reads return the data written on the preceding cycle.

Source files
------------

// File: rtl/mem_stall_responder.sv
// Purpose : data-memory responder that holds each request for LATENCY cycles (stall), then pulses done.
// Latency : valid request done LATENCY cycles after acceptance; rejected request done (with err) next cycle.
// Backpressure: a request presented while busy is ignored, so the initiator must hold or re-present it.
// Ports   : clk/rst (async, active-high); rd/wr/addr/data_in request; data_out/stall/done/err response.
module mem_stall_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int WORDS = 1 << ADDR_BITS;
    // BUSY lasts LATENCY-1 cycles: the counter runs LATENCY-2 down to 0.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [15:0] mem [WORDS];

    state_t                 state, state_n;
    logic [3:0]             cnt, cnt_n;
    logic                   lat_rd, lat_wr;
    logic [ADDR_BITS-1:0]   lat_idx;
    logic [15:0]            lat_data;

    logic                   accept;
    logic                   req_err;
    logic                   out_of_range;
    logic                   acc_we, acc_re;
    logic [ADDR_BITS-1:0]   acc_idx;
    logic [15:0]            acc_data;
    logic                   err_n;

    // Any address bit above the word-index field makes the request out of range.
    assign out_of_range = (32'(addr) >> (ADDR_BITS + 1)) != 32'd0;
    assign req_err      = (rd & wr) | addr[0] | out_of_range;
    assign accept       = (state != BUSY) & (rd | wr);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_we   = 1'b0;
        acc_re   = 1'b0;
        acc_idx  = lat_idx;
        acc_data = lat_data;
        err_n    = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (accept) begin
                    if (req_err) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end else if (LATENCY == 1) begin
                        // Single-cycle latency: access the array straight from the inputs.
                        state_n  = DONE;
                        acc_we   = wr;
                        acc_re   = rd;
                        acc_idx  = addr[ADDR_BITS:1];
                        acc_data = data_in;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_n = DONE;
                    acc_we  = lat_wr;
                    acc_re  = lat_rd;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_rd   <= 1'b0;
            lat_wr   <= 1'b0;
            lat_idx  <= '0;
            lat_data <= 16'h0000;
            stall    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            data_out <= 16'h0000;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_rd   <= rd;
                lat_wr   <= wr;
                lat_idx  <= addr[ADDR_BITS:1];
                lat_data <= data_in;
            end
            stall <= (state_n == BUSY);
            done  <= (state_n == DONE);
            err   <= err_n;
            // Entering DONE: reads capture the word; writes and errors present zero.
            if (state_n == DONE) begin
                data_out <= acc_re ? mem[acc_idx] : 16'h0000;
            end
        end
    end

    // Array is not reset; a write whose commit edge coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (acc_we && !rst) begin
            mem[acc_idx] <= acc_data;
        end
    end

endmodule

// File: tb/tb_mem_stall_responder.sv
module tb_mem_stall_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_i   [3];
    logic        wr_i   [3];
    logic [15:0] addr_i [3];
    logic [15:0] din_i  [3];
    logic [15:0] dout_o [3];
    logic        stall_o[3];
    logic        done_o [3];
    logic        err_o  [3];

    always #5 clk = ~clk;

    // Three instances: LATENCY 3, 4 and 1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stall_responder #(
            .ADDR_BITS(8),
            .LATENCY  ((g == 0) ? 3 : ((g == 1) ? 4 : 1))
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .rd      (rd_i[g]),
            .wr      (wr_i[g]),
            .addr    (addr_i[g]),
            .data_in (din_i[g]),
            .data_out(dout_o[g]),
            .stall   (stall_o[g]),
            .done    (done_o[g]),
            .err     (err_o[g])
        );
    end

    int nchk = 0;
    int nerr = 0;

    // Reference memory: the 32 lowest words of each instance.
    logic [15:0] mdl [3][32];

    function automatic int lat_of(int k);
        return (k == 0) ? 3 : ((k == 1) ? 4 : 1);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one request, then follow it to its done cycle; returns at the
    // falling edge of the done cycle so a following call is back-to-back.
    task automatic req(int k, bit r, bit w, logic [15:0] a, logic [15:0] d);
        bit          e;
        int          lat;
        logic [15:0] expd;
        e    = (r && w) || a[0] || (a >= 16'h0200);
        lat  = e ? 1 : lat_of(k);
        expd = 16'h0000;
        if (!e && r) expd = mdl[k][a[5:1]];
        rd_i[k]   = r;
        wr_i[k]   = w;
        addr_i[k] = a;
        din_i[k]  = d;
        @(posedge clk);
        #1;
        rd_i[k] = 1'b0;
        wr_i[k] = 1'b0;
        if (!e && w) mdl[k][a[5:1]] = d;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check($sformatf("k%0d a%0h stall_done c%0d", k, a, c),
                  {30'd0, stall_o[k], done_o[k]}, {30'd0, c < lat, c == lat});
            if (c == lat) begin
                check($sformatf("k%0d a%0h err", k, a), {31'd0, err_o[k]}, {31'd0, e});
                check($sformatf("k%0d a%0h data", k, a), {16'd0, dout_o[k]}, {16'd0, expd});
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rd_i[k] = 1'b0; wr_i[k] = 1'b0; addr_i[k] = 16'h0; din_i[k] = 16'h0;
        end

        // Reset with arbitrary inputs toggling.
        repeat (3) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                rd_i[k] = 1'($urandom); wr_i[k] = 1'($urandom);
                addr_i[k] = 16'($urandom); din_i[k] = 16'($urandom);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("rst_async k%0d", k),
                  {13'd0, stall_o[k], done_o[k], err_o[k], dout_o[k]}, 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            rd_i[k] = 1'b0; wr_i[k] = 1'b0; addr_i[k] = 16'h0; din_i[k] = 16'h0;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                check($sformatf("post_rst_idle k%0d", k),
                      {13'd0, stall_o[k], done_o[k], err_o[k], dout_o[k]}, 32'd0);
        end
        idle(1);

        // Preload the modelled words of every instance.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 32; i++)
                req(k, 1'b0, 1'b1, 16'(i * 2), 16'($urandom));
        idle(1);

        // LATENCY=3 write then back-to-back read.
        req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(2);

        // Error completions and unchanged contents.
        req(0, 1'b1, 1'b0, 16'h0011, 16'h0000);
        req(0, 1'b1, 1'b1, 16'h0020, 16'h1111);
        req(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        req(0, 1'b1, 1'b0, 16'h0200, 16'h0000);
        idle(2);

        // LATENCY=4: second write held while busy must be ignored.
        rd_i[1] = 1'b0; wr_i[1] = 1'b1; addr_i[1] = 16'h0004; din_i[1] = 16'h1234;
        @(posedge clk); #1;
        addr_i[1] = 16'h0006; din_i[1] = 16'h5678;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("hold stall c%0d", c), {30'd0, stall_o[1], done_o[1]}, 32'd2);
        end
        @(posedge clk); #1;
        wr_i[1] = 1'b0;
        mdl[1][2] = 16'h1234;
        @(negedge clk);
        check("hold done c4", {30'd0, stall_o[1], done_o[1]}, 32'd1);
        check("hold err c4", {31'd0, err_o[1]}, 32'd0);
        for (int c = 5; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("hold quiet c%0d", c), {30'd0, stall_o[1], done_o[1]}, 32'd0);
        end
        idle(1);
        req(1, 1'b1, 1'b0, 16'h0006, 16'h0000);
        req(1, 1'b1, 1'b0, 16'h0004, 16'h0000);
        idle(2);

        // Reset mid-operation discards the write in flight.
        req(0, 1'b0, 1'b1, 16'h0008, 16'h5555);
        idle(1);
        wr_i[0] = 1'b1; addr_i[0] = 16'h0008; din_i[0] = 16'hAAAA;
        @(posedge clk); #1;
        wr_i[0] = 1'b0;
        @(negedge clk);
        check("midrst stall c1", {31'd0, stall_o[0]}, 32'd1);
        @(posedge clk);
        #3;
        check("midrst stall c2", {31'd0, stall_o[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst outs", {13'd0, stall_o[0], done_o[0], err_o[0], dout_o[0]}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midrst no done", {30'd0, stall_o[0], done_o[0]}, 32'd0);
        end
        idle(1);
        req(0, 1'b1, 1'b0, 16'h0008, 16'h0000);
        idle(1);

        // LATENCY=1: alternating write/read every cycle.
        for (int i = 0; i < 8; i++) begin
            req(2, 1'b0, 1'b1, 16'(i * 2), 16'($urandom));
            req(2, 1'b1, 1'b0, 16'(i * 2), 16'h0000);
        end
        idle(2);

        // Randomised traffic against the reference model.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 60; n++) begin
                int          kind;
                logic [15:0] a;
                kind = $urandom_range(0, 9);
                a    = 16'($urandom_range(0, 31) * 2);
                if (kind <= 3)
                    req(k, 1'b0, 1'b1, a, 16'($urandom));
                else if (kind <= 7)
                    req(k, 1'b1, 1'b0, a, 16'h0000);
                else if (kind == 8)
                    req(k, 1'($urandom), 1'b1, a | 16'h0001, 16'($urandom));
                else if ($urandom_range(0, 1) == 0)
                    req(k, 1'b1, 1'b1, a, 16'($urandom));
                else
                    req(k, 1'b0, 1'b1, a | 16'(16'h0200 << $urandom_range(0, 6)), 16'($urandom));
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
            idle(2);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
